// File: rtl/pc_seq_ctrl_pkg.sv
// pc_seq_ctrl_pkg: sequencer states, op-class encodings and the NOP constant.
package pc_seq_ctrl_pkg;
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_EXEC, S_MEM, S_ERR} state_t;
  localparam logic [8:0] OP_R  = 9'h001;
  localparam logic [8:0] OP_I1 = 9'h002;
  localparam logic [8:0] OP_I2 = 9'h004;
  localparam logic [8:0] OP_S2 = 9'h008;
  localparam logic [31:0] NOP = 32'h0000_0013;
  function automatic logic is_mem(input logic [8:0] op);
    return (op == OP_I2) || (op == OP_S2);
  endfunction
endpackage

// File: rtl/pc_seq_ctrl_bus_wait_timer.sv
// pc_seq_ctrl_bus_wait_timer: counts unacknowledged bus wait cycles against a limit.
module pc_seq_ctrl_bus_wait_timer (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_clear,
  input  logic        i_tick,
  input  logic [15:0] i_limit,
  output logic        o_expired
);
  logic [15:0] r_count;
  always_ff @(posedge i_clk)
    r_count <= (!i_rst_n || i_clear) ? '0 : i_tick ? r_count + 16'd1 : r_count;
  assign o_expired = r_count >= i_limit;
endmodule

// File: rtl/pc_seq_ctrl.sv
// pc_seq_ctrl: multi-cycle RV32I fetch/exec/mem sequencer owning the PC; PC_SEQ_INSTRET_EN adds o_instret.
module pc_seq_ctrl
  import pc_seq_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          BUS_TIMEOUT = 255
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_start,
  input  logic        i_halt_req,
  output logic        o_imem_req,
  input  logic        i_imem_ack,
  input  logic [31:0] i_imem_rdata,
  output logic [31:0] o_ir,
  input  logic [8:0]  i_op,
  output logic        o_dmem_req,
  input  logic        i_dmem_ack,
  input  logic [31:0] i_next_pc,
  output logic        o_sign,
  output logic [31:0] o_pc,
  output logic [31:0] o_pc_add_4,
  output logic        o_retire,
  output logic        o_busy,
  output logic        o_err
`ifdef PC_SEQ_INSTRET_EN
  ,
  output logic [63:0] o_instret
`endif
);
  state_t      r_state, w_next;
  logic [31:0] r_pc, r_ir;
  logic        w_wait, w_ack, w_expired, w_commit, w_misal;
  assign w_wait   = (r_state == S_FETCH) || (r_state == S_MEM);
  assign w_ack    = ((r_state == S_FETCH) && i_imem_ack) || ((r_state == S_MEM) && i_dmem_ack);
  assign w_commit = ((r_state == S_EXEC) && !is_mem(i_op)) || ((r_state == S_MEM) && i_dmem_ack);
  assign w_misal  = |i_next_pc[1:0];
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  w_next = i_start ? S_FETCH : S_IDLE;
      S_FETCH: w_next = i_imem_ack ? S_EXEC : w_expired ? S_ERR : S_FETCH;
      S_EXEC:  w_next = is_mem(i_op) ? S_MEM : w_misal ? S_ERR : i_halt_req ? S_IDLE : S_FETCH;
      S_MEM:   w_next = i_dmem_ack ? (w_misal ? S_ERR : i_halt_req ? S_IDLE : S_FETCH)
                      : w_expired ? S_ERR : S_MEM;
      default: w_next = S_ERR;
    endcase
  end
  always_ff @(posedge i_clk)
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_pc    <= RESET_PC;
      r_ir    <= NOP;
    end else begin
      r_state <= w_next;
      if ((r_state == S_FETCH) && i_imem_ack) r_ir <= i_imem_rdata;
      if (o_retire) r_pc <= i_next_pc;
    end
  // Any ack or any non-wait state restarts the count, so MEM->FETCH begins at zero.
  pc_seq_ctrl_bus_wait_timer u_timer (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_clear   (!w_wait || w_ack),
    .i_tick    (w_wait && !w_ack),
    .i_limit   (16'(BUS_TIMEOUT)),
    .o_expired (w_expired)
  );
  assign o_imem_req = r_state == S_FETCH;
  assign o_dmem_req = r_state == S_MEM;
  assign o_sign     = (r_state == S_MEM) && i_dmem_ack;
  assign o_retire   = w_commit && !w_misal;
  assign o_busy     = (r_state != S_IDLE) && (r_state != S_ERR);
  assign o_err      = r_state == S_ERR;
  assign o_pc       = r_pc;
  assign o_pc_add_4 = r_pc + 32'd4;
  assign o_ir       = r_ir;
`ifdef PC_SEQ_INSTRET_EN
  logic [63:0] r_instret;
  always_ff @(posedge i_clk)
    r_instret <= !i_rst_n ? '0 : r_instret + 64'(o_retire);
  assign o_instret = r_instret;
`endif
endmodule
